clock_divider_multi: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clock_divider_multi_if.sv | 26 ++
 rtl/clkdiv_channel.sv | 79 +++++++
 rtl/clock_divider_multi.sv | 74 +++++++
 tb/tb_clock_divider_multi.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and request type for clock_divider_multi
package clkdiv_pkg;

    localparam int DEFAULT_HALF_100K = 250;
    localparam int DEFAULT_HALF_400K = 63;

    localparam int CFG_CH_W   = 8;
    localparam int CFG_HALF_W = 16;

    typedef struct packed {
        logic [CFG_CH_W-1:0]   ch;
        logic [CFG_HALF_W-1:0] half;
    } clkdiv_cfg_t;

endpackage

// File: rtl/clock_divider_multi_if.sv
// rtl/clock_divider_multi_if.sv - half-period update request/accept handshake
interface clock_divider_multi_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 16
);

    logic             i_cfg_valid;
    logic [CH_W-1:0]  i_cfg_ch;
    logic [CNT_W-1:0] i_cfg_half;
    logic             o_cfg_ready;

    modport master (
        output i_cfg_valid,
        output i_cfg_ch,
        output i_cfg_half,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_ch,
        input  i_cfg_half,
        output o_cfg_ready
    );

endinterface

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel: counter, level, edge strobes, pending half-period
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = DEFAULT_HALF_100K
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_half,
    output logic             o_pend,
    output logic             o_clk,
    output logic             o_rise,
    output logic             o_fall
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic [CNT_W-1:0] eff_half;
    logic             pend;
    logic             tc;

    // A zero half-period runs as one, giving i_clk/2.
    assign eff_half = (half == '0) ? CNT_W'(1) : half;
    assign tc       = (cnt == eff_half - CNT_W'(1));
    assign o_pend   = pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            half      <= CNT_W'(DEFAULT_HALF);
            pend_half <= CNT_W'(DEFAULT_HALF);
            pend      <= 1'b0;
            o_clk     <= 1'b0;
            o_rise    <= 1'b0;
            o_fall    <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            // Sync and disable both park the channel low; a parked channel has
            // no terminal count to wait for, so any pending value lands now.
            if (i_sync || !i_en) begin
                cnt    <= '0;
                o_clk  <= 1'b0;
                o_fall <= o_clk;
                if (pend) begin
                    half <= pend_half;
                    pend <= 1'b0;
                end
            end else if (tc) begin
                cnt    <= '0;
                o_clk  <= ~o_clk;
                o_rise <= ~o_clk;
                o_fall <= o_clk;
                if (pend) begin
                    half <= pend_half;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Accept comes last so a same-cycle terminal count or sync cannot
            // swallow the newly latched value.
            if (i_cfg_we) begin
                if (i_en) begin
                    pend_half <= i_cfg_half;
                    pend      <= 1'b1;
                end else begin
                    half <= i_cfg_half;
                end
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel clock divider top; CLKDIV_SYNC_EN enables i_sync phase alignment
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = DEFAULT_HALF_100K
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_CH-1:0]     i_en,
    input  logic                  i_sync,
    clock_divider_multi_if.slave  cfg,
    output logic [NUM_CH-1:0]     o_clk,
    output logic [NUM_CH-1:0]     o_rise,
    output logic [NUM_CH-1:0]     o_fall
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   req_ch;
    logic [CNT_W-1:0]  req_half;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] cfg_we;
    logic              ready;
    logic              sync;

    assign req_ch   = cfg.i_cfg_ch;
    assign req_half = cfg.i_cfg_half;

`ifdef CLKDIV_SYNC_EN
    assign sync = i_sync;
`else
    logic unused_sync;
    assign unused_sync = i_sync;
    assign sync        = 1'b0;
`endif

    // Requests to channel numbers that do not exist are accepted and dropped.
    always_comb begin
        ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_ch == CH_W'(c)) ready = ~pend[c];
        end
    end

    assign cfg.o_cfg_ready = ready;

    always_comb begin
        cfg_we = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_we[c] = cfg.i_cfg_valid && ready && (req_ch == CH_W'(c));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_en       (i_en[c]),
            .i_sync     (sync),
            .i_cfg_we   (cfg_we[c]),
            .i_cfg_half (req_half),
            .o_pend     (pend[c]),
            .o_clk      (o_clk[c]),
            .o_rise     (o_rise[c]),
            .o_fall     (o_fall[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - directed self-checking bench for clock_divider_multi
module tb_clock_divider_multi;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] oclk;
    logic [NUM_CH-1:0] orise;
    logic [NUM_CH-1:0] ofall;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    clock_divider_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

    clock_divider_multi #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (250)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_sync (sync),
        .cfg    (cfg_if),
        .o_clk  (oclk),
        .o_rise (orise),
        .o_fall (ofall)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [NUM_CH-1:0] en_after);
        rst                = 1'b1;
        en                 = en_after;
        sync               = 1'b0;
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_ch    = '0;
        cfg_if.i_cfg_half  = '0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic cfg_write(input int ch, input int half);
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_ch    = CH_W'(ch);
        cfg_if.i_cfg_half  = CNT_W'(half);
        step();
        cfg_if.i_cfg_valid = 1'b0;
    endtask

    task automatic wait_edge(input int ch, input bit rising, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (rising ? orise[ch] : ofall[ch]) at = cyc;
        end
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        en                 = 3'b011;
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_ch    = '0;
        cfg_if.i_cfg_half  = '0;
        step();
        step();
        n_cmp++;
        if ({oclk, orise, ofall} !== 9'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b, expected 0", {oclk, orise, ofall});
        end
        n_cmp++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b, expected 1", cfg_if.o_cfg_ready);
        end
    endtask

    task automatic test_default_period();
        int r1 = -1, f1 = -1, r2 = -1;
        bit ch1_act = 1'b0;
        do_reset(3'b001);
        repeat (760) begin
            step();
            if (orise[0]) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            if (ofall[0] && f1 < 0) f1 = cyc;
            if (oclk[1] | orise[1] | ofall[1]) ch1_act = 1'b1;
        end
        n_cmp++;
        if (r1 !== 250) begin n_bad++; $display("FAIL default_first_rise: got %0d, expected 250", r1); end
        n_cmp++;
        if (f1 !== 500) begin n_bad++; $display("FAIL default_first_fall: got %0d, expected 500", f1); end
        n_cmp++;
        if (r2 !== 750) begin n_bad++; $display("FAIL default_second_rise: got %0d, expected 750", r2); end
        n_cmp++;
        if (ch1_act !== 1'b0) begin n_bad++; $display("FAIL idle_ch1_activity: got %b, expected 0", ch1_act); end
    endtask

    task automatic test_retune();
        int at;
        do_reset(3'b001);
        wait_edge(0, 1'b1, 300, at);
        n_cmp++;
        if (at !== 250) begin n_bad++; $display("FAIL retune_pre_rise: got %0d, expected 250", at); end
        while (cyc < 260) step();
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_ch    = 2'd0;
        cfg_if.i_cfg_half  = 16'd10;
        #1;
        n_cmp++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL retune_ready_idle: got %b, expected 1", cfg_if.o_cfg_ready); end
        step();
        cfg_if.i_cfg_valid = 1'b0;
        #1;
        n_cmp++;
        if (cfg_if.o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL retune_ready_pending: got %b, expected 0", cfg_if.o_cfg_ready); end
        cfg_if.i_cfg_ch = 2'd1;
        #1;
        n_cmp++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL retune_ready_other_ch: got %b, expected 1", cfg_if.o_cfg_ready); end
        cfg_if.i_cfg_ch = 2'd0;
        #1;
        while (cyc < 499) step();
        n_cmp++;
        if ({cfg_if.o_cfg_ready, oclk[0]} !== 2'b01) begin
            n_bad++; $display("FAIL retune_before_swap: got ready,clk=%b, expected 01", {cfg_if.o_cfg_ready, oclk[0]});
        end
        step();
        n_cmp++;
        if ({cfg_if.o_cfg_ready, ofall[0]} !== 2'b11) begin
            n_bad++; $display("FAIL retune_swap_fall: got ready,fall=%b, expected 11", {cfg_if.o_cfg_ready, ofall[0]});
        end
        wait_edge(0, 1'b1, 30, at);
        n_cmp++;
        if (at !== 510) begin n_bad++; $display("FAIL retune_new_rise: got %0d, expected 510", at); end
        wait_edge(0, 1'b0, 30, at);
        n_cmp++;
        if (at !== 520) begin n_bad++; $display("FAIL retune_new_fall: got %0d, expected 520", at); end
    endtask

    task automatic test_half_min();
        do_reset(3'b000);
        for (int pass = 0; pass < 2; pass++) begin
            cfg_write(1, pass);
            en = 3'b010;
            for (int k = 1; k <= 6; k++) begin
                logic odd;
                odd = (k % 2) == 1;
                step();
                n_cmp++;
                if ({oclk[1], orise[1], ofall[1]} !== {odd, odd, ~odd}) begin
                    n_bad++;
                    $display("FAIL half_min_toggle: half=%0d step=%0d got clk,rise,fall=%b, expected %b",
                             pass, k, {oclk[1], orise[1], ofall[1]}, {odd, odd, ~odd});
                end
            end
            en = 3'b000;
            step();
        end
    endtask

    task automatic test_disable();
        int at;
        int s;
        do_reset(3'b001);
        wait_edge(0, 1'b1, 300, at);
        en = 3'b000;
        step();
        n_cmp++;
        if ({oclk[0], ofall[0]} !== 2'b01) begin
            n_bad++; $display("FAIL disable_fall: got clk,fall=%b, expected 01", {oclk[0], ofall[0]});
        end
        step();
        n_cmp++;
        if ({oclk[0], orise[0], ofall[0]} !== 3'b000) begin
            n_bad++; $display("FAIL disable_single_fall: got %b, expected 000", {oclk[0], orise[0], ofall[0]});
        end
        cfg_write(0, 5);
        en = 3'b001;
        s  = cyc;
        wait_edge(0, 1'b1, 20, at);
        n_cmp++;
        if (at - s !== 5) begin n_bad++; $display("FAIL reenable_rise_delay: got %0d, expected 5", at - s); end
    endtask

    task automatic test_sync();
        int s;
        do_reset(3'b000);
        cfg_write(0, 7);
        cfg_write(1, 3);
        en = 3'b011;
        s  = cyc;
        while (cyc < s + 10) step();
        n_cmp++;
        if (oclk[1:0] !== 2'b11) begin n_bad++; $display("FAIL sync_pre_levels: got %b, expected 11", oclk[1:0]); end
        sync = 1'b1;
        step();
        sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
        begin
            int r0 = -1, r1 = -1;
            n_cmp++;
            if ({oclk[1:0], ofall[1:0]} !== 4'b0011) begin
                n_bad++; $display("FAIL sync_align: got clk,fall=%b, expected 0011", {oclk[1:0], ofall[1:0]});
            end
            for (int i = 1; i <= 8; i++) begin
                step();
                if (orise[0] && r0 < 0) r0 = i;
                if (orise[1] && r1 < 0) r1 = i;
            end
            n_cmp++;
            if (r1 !== 3) begin n_bad++; $display("FAIL sync_ch1_rise: got %0d, expected 3", r1); end
            n_cmp++;
            if (r0 !== 7) begin n_bad++; $display("FAIL sync_ch0_rise: got %0d, expected 7", r0); end
        end
`else
        n_cmp++;
        if ({oclk[1:0], orise[1:0], ofall[1:0]} !== 6'b110000) begin
            n_bad++; $display("FAIL sync_ignored: got clk,rise,fall=%b, expected 110000", {oclk[1:0], orise[1:0], ofall[1:0]});
        end
        step();
        n_cmp++;
        if (ofall[1] !== 1'b1) begin n_bad++; $display("FAIL sync_ignored_ch1_fall: got %b, expected 1", ofall[1]); end
`endif
    endtask

    task automatic test_range_and_reset();
        int at;
        do_reset(3'b001);
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_ch    = 2'd3;
        cfg_if.i_cfg_half  = 16'd10;
        #1;
        n_cmp++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL range_ready: got %b, expected 1", cfg_if.o_cfg_ready); end
        step();
        cfg_if.i_cfg_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_if.i_cfg_ch = CH_W'(c);
            #1;
            n_cmp++;
            if (cfg_if.o_cfg_ready !== 1'b1) begin
                n_bad++; $display("FAIL range_no_pend: ch=%0d got %b, expected 1", c, cfg_if.o_cfg_ready);
            end
        end
        wait_edge(0, 1'b1, 300, at);
        n_cmp++;
        if (at !== 250) begin n_bad++; $display("FAIL range_ch0_unchanged: got %0d, expected 250", at); end
        cfg_write(1, 4);
        while (cyc < 260) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({oclk, orise, ofall} !== 9'b0) begin
            n_bad++; $display("FAIL midrun_reset_outputs: got %b, expected 0", {oclk, orise, ofall});
        end
        rst = 1'b0;
        en  = 3'b010;
        cyc = 0;
        wait_edge(1, 1'b1, 300, at);
        n_cmp++;
        if (at !== 250) begin n_bad++; $display("FAIL reset_restores_half: got %0d, expected 250", at); end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_retune();
        test_half_min();
        test_disable();
        test_sync();
        test_range_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
